// File: rtl/pad_cfg_ctrl.sv
// Pad configuration sequencer: shadow registers written over a req/ack port, applied to io_cells one pad at a time in round-robin order.
// Latency: register ack 1 cycle after the request edge; same-direction config applied 2 edges after the write, direction change 2+TURN_CYCLES edges.
// Backpressure: none on the register port (fixed 1-cycle ack); writes during sequencing only update the shadow and re-queue the pad.
module pad_cfg_ctrl #(
    parameter int                    NUM_PADS    = 8,
    parameter int                    CONF_WIDTH  = 3,
    parameter int                    TURN_CYCLES = 2,
    parameter logic [CONF_WIDTH-1:0] RESET_CFG   = 3'b001
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           cfg_req,
    input  logic                           cfg_we,
    input  logic [4:0]                     cfg_addr,
    input  logic [CONF_WIDTH-1:0]          cfg_wdata,
    output logic [31:0]                    cfg_rdata,
    output logic                           cfg_ack,
    output logic [NUM_PADS*CONF_WIDTH-1:0] io_cell_cfg,
    output logic [NUM_PADS-1:0]            rx_valid,
    output logic                           busy
);

    localparam int         PW          = $clog2(NUM_PADS);
    localparam int         CW          = $clog2(TURN_CYCLES + 1);
    localparam logic [4:0] PAD_LIMIT   = 5'(NUM_PADS);
    localparam logic [4:0] STATUS_ADDR = 5'(NUM_PADS);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISOLATE = 2'd1,
        S_APPLY   = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    // Per-pad storage: what software asked for and what the io_cell currently sees.
    logic [CONF_WIDTH-1:0] shadow  [NUM_PADS];
    logic [CONF_WIDTH-1:0] applied [NUM_PADS];
    logic [NUM_PADS-1:0]   pending;

    // Transition context for the single pad being sequenced.
    logic [PW-1:0]         sel;
    logic [CONF_WIDTH-1:0] tgt;
    logic [CW-1:0]         turn_cnt;
    logic                  reseq;
    logic [PW-1:0]         ptr;

    // Register port decode.
    logic                  accept;
    logic                  wr_pad;
    logic [PW-1:0]         wr_idx;
    logic [31:0]           read_mux;

    // Round-robin pick.
    logic                  pick_vld;
    logic [PW-1:0]         pick_idx;
    logic                  dir_diff;

    // A request is taken only while ack is low, so a held req yields one ack pulse followed by a gap.
    assign accept   = cfg_req & ~cfg_ack;
    assign wr_idx   = cfg_addr[PW-1:0];
    assign wr_pad   = accept & cfg_we & (cfg_addr < PAD_LIMIT);
    assign busy     = (state != S_IDLE);
    assign dir_diff = shadow[pick_idx][0] ^ applied[pick_idx][0];

    // Read data selection: pad shadow, status word {pending, busy}, or zero for unmapped space.
    always_comb begin
        read_mux = '0;
        if (cfg_addr < PAD_LIMIT) begin
            read_mux[CONF_WIDTH-1:0] = shadow[wr_idx];
        end else if (cfg_addr == STATUS_ADDR) begin
            read_mux[NUM_PADS:0] = {pending, busy};
        end
    end

    // First pending pad at or after the pointer, wrapping past the last pad.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        for (int k = 0; k < NUM_PADS; k++) begin
            int            cand;
            logic [PW-1:0] cand_idx;
            cand = int'(ptr) + k;
            if (cand >= NUM_PADS) begin
                cand = cand - NUM_PADS;
            end
            cand_idx = PW'(cand);
            if (!pick_vld && pending[cand_idx]) begin
                pick_vld = 1'b1;
                pick_idx = cand_idx;
            end
        end
    end

    // Register port: one-cycle ack, read data only meaningful while ack is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg_ack   <= 1'b0;
            cfg_rdata <= '0;
        end else begin
            cfg_ack   <= accept;
            cfg_rdata <= '0;
            if (accept && !cfg_we) begin
                cfg_rdata <= read_mux;
            end
        end
    end

    // Shadow and pending bookkeeping; a write in the APPLY cycle beats the clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_PADS; i++) begin
                shadow[i] <= RESET_CFG;
            end
            pending <= '0;
        end else begin
            if (state == S_APPLY && !reseq) begin
                pending[sel] <= 1'b0;
            end
            if (wr_pad) begin
                shadow[wr_idx]  <= cfg_wdata;
                pending[wr_idx] <= 1'b1;
            end
        end
    end

    // Sequencer state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: isolate first only when the direction bit flips.
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (pick_vld) begin
                    state_nxt = dir_diff ? S_ISOLATE : S_APPLY;
                end
            end
            S_ISOLATE: begin
                if (turn_cnt == CW'(1)) begin
                    state_nxt = S_APPLY;
                end
            end
            S_APPLY: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Transition context: latch the pad and its target, count isolation, and note late rewrites of that pad.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel      <= '0;
            tgt      <= RESET_CFG;
            turn_cnt <= '0;
            reseq    <= 1'b0;
            ptr      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pick_vld) begin
                        sel      <= pick_idx;
                        tgt      <= shadow[pick_idx];
                        turn_cnt <= CW'(TURN_CYCLES);
                        // The write racing the pick updates the shadow after tgt was taken.
                        reseq    <= wr_pad && (wr_idx == pick_idx);
                    end
                end
                S_ISOLATE: begin
                    turn_cnt <= turn_cnt - CW'(1);
                    if (wr_pad && (wr_idx == sel)) begin
                        reseq <= 1'b1;
                    end
                end
                S_APPLY: begin
                    ptr <= (sel == PW'(NUM_PADS - 1)) ? '0 : sel + PW'(1);
                end
                default: begin
                    ptr <= ptr;
                end
            endcase
        end
    end

    // Applied config: tri-state and mask the pad on a direction flip, then drive the target.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_PADS; i++) begin
                applied[i] <= RESET_CFG;
            end
            rx_valid <= '1;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pick_vld && dir_diff) begin
                        applied[pick_idx][0] <= 1'b1;
                        rx_valid[pick_idx]   <= 1'b0;
                    end
                end
                S_APPLY: begin
                    applied[sel]  <= tgt;
                    rx_valid[sel] <= 1'b1;
                end
                default: begin
                    rx_valid <= rx_valid;
                end
            endcase
        end
    end

    // Flatten the applied array onto the io_cell bus.
    always_comb begin
        io_cell_cfg = '0;
        for (int i = 0; i < NUM_PADS; i++) begin
            io_cell_cfg[i*CONF_WIDTH +: CONF_WIDTH] = applied[i];
        end
    end

endmodule

// File: tb/tb_pad_cfg_ctrl.sv
// Bench for pad_cfg_ctrl: directed register accesses with literal expectations,
// plus a job-timeline model of the sequencer compared against the DUT every cycle.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_pad_cfg_ctrl;

    localparam int N  = 8;
    localparam int W  = 3;
    localparam int TC = 2;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           cfg_req = 1'b0;
    logic           cfg_we = 1'b0;
    logic [4:0]     cfg_addr = '0;
    logic [W-1:0]   cfg_wdata = '0;
    logic [31:0]    cfg_rdata;
    logic           cfg_ack;
    logic [N*W-1:0] io_cell_cfg;
    logic [N-1:0]   rx_valid;
    logic           busy;

    int checks   = 0;
    int failures = 0;

    pad_cfg_ctrl #(
        .NUM_PADS   (N),
        .CONF_WIDTH (W),
        .TURN_CYCLES(TC),
        .RESET_CFG  (3'b001)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_req    (cfg_req),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_wdata  (cfg_wdata),
        .cfg_rdata  (cfg_rdata),
        .cfg_ack    (cfg_ack),
        .io_cell_cfg(io_cell_cfg),
        .rx_valid   (rx_valid),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model: pads as arrays, the sequencer as one timed job ----------------
    logic [W-1:0] m_shadow  [N];
    logic [W-1:0] m_applied [N];
    logic [N-1:0] m_pending;
    logic [N-1:0] m_rxv;
    int           m_ptr;
    int           job_pad;
    int           job_age;
    int           job_len;
    bit           job_rew;
    logic [W-1:0] job_tgt;
    bit           m_ack;
    logic [31:0]  m_rdata;

    task automatic m_reset();
        for (int i = 0; i < N; i++) begin
            m_shadow[i]  = 3'b001;
            m_applied[i] = 3'b001;
        end
        m_pending = '0;
        m_rxv     = '1;
        m_ptr     = 0;
        job_pad   = -1;
        job_age   = 0;
        job_len   = 1;
        job_rew   = 0;
        job_tgt   = 3'b001;
        m_ack     = 0;
        m_rdata   = '0;
    endtask

    task automatic m_step();
        bit accept;
        bit is_wr;
        int a;
        accept = cfg_req && !m_ack;
        a      = int'(cfg_addr);
        is_wr  = accept && cfg_we && (a < N);
        m_rdata = '0;
        if (accept && !cfg_we) begin
            if (a < N) m_rdata = 32'(m_shadow[a]);
            else if (a == N) m_rdata = (32'(m_pending) << 1) | 32'(job_pad >= 0);
        end
        m_ack = accept;
        if (job_pad >= 0) begin
            job_age++;
            if (job_age == job_len) begin
                m_applied[job_pad] = job_tgt;
                m_rxv[job_pad]     = 1'b1;
                if (!job_rew) m_pending[job_pad] = 1'b0;
                m_ptr   = (job_pad + 1) % N;
                job_pad = -1;
            end
        end else if (m_pending != '0) begin
            for (int k = 0; k < N; k++) begin
                int c;
                c = (m_ptr + k) % N;
                if (job_pad < 0 && m_pending[c]) job_pad = c;
            end
            job_tgt = m_shadow[job_pad];
            job_age = 0;
            job_rew = 0;
            if (job_tgt[0] != m_applied[job_pad][0]) begin
                m_applied[job_pad][0] = 1'b1;
                m_rxv[job_pad]        = 1'b0;
                job_len               = TC + 1;
            end else begin
                job_len = 1;
            end
        end
        if (is_wr) begin
            m_shadow[a]  = cfg_wdata;
            m_pending[a] = 1'b1;
            if (job_pad == a) job_rew = 1;
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) m_reset();
        else     m_step();
    end

    function automatic logic [N*W-1:0] exp_cfg();
        logic [N*W-1:0] v;
        v = '0;
        for (int i = 0; i < N; i++) v[i*W +: W] = m_applied[i];
        return v;
    endfunction

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (!rst) begin
            check("io_cell_cfg", 32'(io_cell_cfg), 32'(exp_cfg()));
            check("rx_valid", 32'(rx_valid), 32'(m_rxv));
            check("busy", 32'(busy), 32'(job_pad >= 0));
            check("cfg_ack", 32'(cfg_ack), 32'(m_ack));
            if (m_ack) check("cfg_rdata", cfg_rdata, m_rdata);
        end
    end

    // ---------------- directed stimulus ----------------
    function automatic logic [W-1:0] pad(input int i);
        return io_cell_cfg[i*W +: W];
    endfunction

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Returns on the falling edge right after the sampling edge k.
    task automatic access(input bit we, input int a, input logic [W-1:0] d, output logic [31:0] rd);
        bit got;
        got = 0;
        @(negedge clk);
        cfg_req   = 1'b1;
        cfg_we    = we;
        cfg_addr  = 5'(a);
        cfg_wdata = d;
        for (int n = 0; n < 6 && !got; n++) begin
            @(negedge clk);
            got = cfg_ack;
        end
        rd      = cfg_rdata;
        cfg_req = 1'b0;
        cfg_we  = 1'b0;
        check("ack_seen", 32'(got), 32'd1);
    endtask

    localparam logic [N*W-1:0] ALL_RESET = {N{3'b001}};

    initial begin
        logic [31:0] rd;
        rst = 1'b1;
        cycles(3);
        rst = 1'b0;

        // reset state
        check("rst_cfg", 32'(io_cell_cfg), 32'(ALL_RESET));
        check("rst_rxv", 32'(rx_valid), 32'hFF);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ack", 32'(cfg_ack), 32'd0);
        access(0, 3, '0, rd);
        check("rd_pad3_reset", rd, 32'h1);

        // same-direction write to pad 2
        access(1, 2, 3'b101, rd);
        check("p2_k", 32'(pad(2)), 32'h1);
        cycles(1);
        check("p2_k1", 32'(pad(2)), 32'h1);
        check("p2_rxv", 32'(rx_valid), 32'hFF);
        cycles(1);
        check("p2_k2", 32'(pad(2)), 32'h5);
        cycles(1);
        access(0, N, '0, rd);
        check("status_idle", rd, 32'h0);

        // pad 3 moves the pointer to 4
        access(1, 3, 3'b011, rd);
        cycles(3);
        check("p3_set", 32'(pad(3)), 32'h3);

        // queued writes 7 (direction flip), 0, 3 while pointer is 4
        access(1, 7, 3'b110, rd);
        access(1, 0, 3'b011, rd);
        access(1, 3, 3'b001, rd);
        check("q_p7", 32'(pad(7)), 32'h6);
        check("q_p0_old", 32'(pad(0)), 32'h1);
        cycles(2);
        check("q_p0", 32'(pad(0)), 32'h3);
        check("q_p3_old", 32'(pad(3)), 32'h3);
        cycles(2);
        check("q_p3", 32'(pad(3)), 32'h1);
        check("q_busy", 32'(busy), 32'd0);

        // pad 5 input -> output
        cycles(1);
        access(1, 5, 3'b000, rd);
        check("p5_k_rxv", 32'(rx_valid[5]), 32'd1);
        cycles(1);
        check("p5_k1_rxv", 32'(rx_valid[5]), 32'd0);
        check("p5_k1_cfg", 32'(pad(5)), 32'h1);
        check("p5_k1_busy", 32'(busy), 32'd1);
        cycles(2);
        check("p5_k3_rxv", 32'(rx_valid[5]), 32'd0);
        cycles(1);
        check("p5_k4_cfg", 32'(pad(5)), 32'h0);
        check("p5_k4_rxv", 32'(rx_valid[5]), 32'd1);

        // pad 6 rewritten during its isolation
        cycles(2);
        access(1, 6, 3'b000, rd);
        access(1, 6, 3'b011, rd);
        cycles(2);
        check("p6_first", 32'(pad(6)), 32'h0);
        check("p6_first_rxv", 32'(rx_valid[6]), 32'd1);
        cycles(1);
        check("p6_reiso", 32'(pad(6)), 32'h1);
        check("p6_reiso_rxv", 32'(rx_valid[6]), 32'd0);
        cycles(3);
        check("p6_final", 32'(pad(6)), 32'h3);
        check("p6_final_rxv", 32'(rx_valid[6]), 32'd1);

        // reset during isolation of pad 1
        cycles(2);
        access(1, 1, 3'b000, rd);
        cycles(1);
        check("p1_iso", 32'(rx_valid[1]), 32'd0);
        #2 rst = 1'b1;
        #1;
        check("arst_cfg", 32'(io_cell_cfg), 32'(ALL_RESET));
        check("arst_rxv", 32'(rx_valid), 32'hFF);
        check("arst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        access(0, 20, '0, rd);
        check("rd_unmapped", rd, 32'h0);
        access(0, 1, '0, rd);
        check("rd_pad1_after_rst", rd, 32'h1);
        access(0, N, '0, rd);
        check("status_after_rst", rd, 32'h0);
        cycles(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL global_timeout: simulation did not complete");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
